// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types for the data-memory master bridge:
// response codes, bridge FSM states and the data-access prot value.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } dmem_axil_state_t;

  localparam logic [2:0] AXIL_PROT_DATA = 3'b000;

endpackage

// File: rtl/dmem_axil_master.sv
// CPU dmem port to AXI4-Lite master bridge, one outstanding access.
// Ports: clk/rst_n (sync, low), dmem_* request/response, m_axi_* bus.
module dmem_axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [2:0] AXI_PROT = AXIL_PROT_DATA,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_write_data,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [STRB_WIDTH-1:0] dmem_byte_enable,
  output logic [DATA_WIDTH-1:0] dmem_read_data,
  output logic                  dmem_ready,
  output logic                  dmem_error,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  dmem_axil_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  axil_resp_t            resp_q, resp_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic arvalid_q, arvalid_d;
  logic bready_q, bready_d;
  logic rready_q, rready_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic ready_q, ready_d;
  logic error_q, error_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_fin, w_fin, accept;

  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q & m_axi_wready;
  assign ar_hs  = arvalid_q & m_axi_arready;
  assign b_hs   = bready_q & m_axi_bvalid;
  assign r_hs   = rready_q & m_axi_rvalid;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;
  // The request is still held during the completion pulse;
  // it must not be taken as a new transaction.
  assign accept = (state_q == IDLE) & ~ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && dmem_write)
          state_d = WR_REQ;
        else if (accept && dmem_read)
          state_d = RD_REQ;
      end
      WR_REQ:  if (aw_fin && w_fin) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = DONE;
      RD_REQ:  if (ar_hs) state_d = RD_RESP;
      RD_RESP: if (r_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && dmem_write) begin
          addr_d    = dmem_addr;
          wdata_d   = dmem_write_data;
          strb_d    = dmem_byte_enable;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (accept && dmem_read) begin
          addr_d    = dmem_addr;
          arvalid_d = 1'b1;
        end
      end
      WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin)
          bready_d = 1'b1;
      end
      WR_RESP: begin
        if (b_hs) begin
          resp_d   = axil_resp_t'(m_axi_bresp);
          bready_d = 1'b0;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          rdata_d  = m_axi_rdata;
          resp_d   = axil_resp_t'(m_axi_rresp);
          rready_d = 1'b0;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        error_d = (resp_q != OKAY);
      end
      default: ;
    endcase
  end

  assign m_axi_awaddr   = addr_q & ~ADDR_WIDTH'(3);
  assign m_axi_araddr   = addr_q & ~ADDR_WIDTH'(3);
  assign m_axi_awprot   = AXI_PROT;
  assign m_axi_arprot   = AXI_PROT;
  assign m_axi_awvalid  = awvalid_q;
  assign m_axi_wdata    = wdata_q;
  assign m_axi_wstrb    = strb_q;
  assign m_axi_wvalid   = wvalid_q;
  assign m_axi_bready   = bready_q;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready_q;
  assign dmem_read_data = rdata_q;
  assign dmem_ready     = ready_q;
  assign dmem_error     = error_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_axil_master.sv
// Bench for dmem_axil_master: table of transactions against a
// wait-programmable AXI4-Lite slave, scoreboard of completions.
module tb_dmem_axil_master;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dmem_addr, dmem_write_data, dmem_read_data;
  logic        dmem_read, dmem_write, dmem_ready, dmem_error, busy;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  dmem_axil_master dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_read_data(dmem_read_data), .dmem_ready(dmem_ready),
    .dmem_error(dmem_error), .busy(busy),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // slave configuration, set per transaction
  int          aw_wait, w_wait, ar_wait, resp_wait;
  logic [1:0]  cfg_resp;
  logic [31:0] cfg_rdata;

  // slave observations
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
  int          b_iss = 0, r_iss = 0;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit          b_sched, r_sched;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  // Ready/valid decisions are taken on the falling edge; a ready
  // raised here while valid is high means a handshake at the next
  // rising edge, so the handshake is counted here.
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; rvalid = 0; bresp = 0; rresp = 0; rdata = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      b_sched = 0; r_sched = 0;
      b_iss = (aw_hs < w_hs) ? aw_hs : w_hs;
      r_iss = ar_hs;
    end else begin
      if (b_sched) begin
        bvalid = 0; b_sched = 0; b_hs++;
      end else if (bvalid) begin
        if (bready) b_sched = 1;
      end else if (((aw_hs < w_hs) ? aw_hs : w_hs) > b_iss) begin
        if (b_cnt == resp_wait) begin
          bvalid = 1; bresp = cfg_resp; b_iss++; b_cnt = 0;
          if (bready) b_sched = 1;
        end else b_cnt++;
      end
      if (r_sched) begin
        rvalid = 0; r_sched = 0; r_hs++;
      end else if (rvalid) begin
        if (rready) r_sched = 1;
      end else if (ar_hs > r_iss) begin
        if (r_cnt == resp_wait) begin
          rvalid = 1; rresp = cfg_resp; rdata = cfg_rdata;
          r_iss++; r_cnt = 0;
          if (rready) r_sched = 1;
        end else r_cnt++;
      end
      if (awvalid && !awready) begin
        if (aw_cnt == aw_wait) begin
          awready = 1; aw_hs++; cap_awaddr = awaddr;
        end else aw_cnt++;
      end else begin
        awready = 0; aw_cnt = 0;
      end
      if (wvalid && !wready) begin
        if (w_cnt == w_wait) begin
          wready = 1; w_hs++; cap_wdata = wdata; cap_wstrb = wstrb;
        end else w_cnt++;
      end else begin
        wready = 0; w_cnt = 0;
      end
      if (arvalid && !arready) begin
        if (ar_cnt == ar_wait) begin
          arready = 1; ar_hs++; cap_araddr = araddr;
        end else ar_cnt++;
      end else begin
        arready = 0; ar_cnt = 0;
      end
    end
  end

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          aw_w;
    int          w_w;
    int          ar_w;
    int          rsp_w;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          chk_data;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  vec_t vt[9];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    aw_wait = v.aw_w; w_wait = v.w_w; ar_wait = v.ar_w;
    resp_wait = v.rsp_w; cfg_resp = v.resp; cfg_rdata = v.rdata;
    dmem_addr = v.addr; dmem_write_data = v.data;
    dmem_byte_enable = v.be;
    dmem_write = v.wr; dmem_read = v.rd;
  endtask

  task automatic run(input int k, input vec_t v);
    int   awc, wc, arc, lat, bhs0;
    bit   got;
    exp_t e;
    string tag;
    tag = $sformatf("v%0d", k);
    awc = 0; wc = 0; arc = 0; lat = 0; got = 0; bhs0 = b_hs;
    @(negedge clk);
    drive(v);
    sb.push_back('{chk_data: !v.wr, data: v.rdata, err: v.exp_err});
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      awc += int'(awvalid); wc += int'(wvalid); arc += int'(arvalid);
      if (dmem_ready) begin
        got = 1; lat = i - 1;
        dmem_write = 0; dmem_read = 0;
        if (sb.size() == 0) begin
          chk({tag, " sb_empty"}, 1, 0);
        end else begin
          e = sb.pop_front();
          chk({tag, " err"}, 32'(dmem_error), 32'(e.err));
          if (e.chk_data) chk({tag, " rdata"}, dmem_read_data, e.data);
        end
        chk({tag, " lat"}, lat, v.exp_lat);
        chk({tag, " busy_done"}, 32'(busy), 0);
      end
    end
    if (!got) begin
      chk({tag, " timeout"}, 0, 1);
      dmem_write = 0; dmem_read = 0;
    end
    @(negedge clk);
    chk({tag, " one_pulse"}, 32'(dmem_ready), 0);
    chk({tag, " busy_after"}, 32'(busy), 0);
    if (v.wr) begin
      chk({tag, " awaddr"}, cap_awaddr, v.exp_addr);
      chk({tag, " wdata"}, cap_wdata, v.data);
      chk({tag, " wstrb"}, 32'(cap_wstrb), 32'(v.be));
      chk({tag, " aw_cyc"}, awc, v.aw_w + 1);
      chk({tag, " w_cyc"}, wc, v.w_w + 1);
      chk({tag, " ar_cyc"}, arc, 0);
      chk({tag, " b_cnt"}, b_hs - bhs0, 1);
    end else begin
      chk({tag, " araddr"}, cap_araddr, v.exp_addr);
      chk({tag, " ar_cyc"}, arc, v.ar_w + 1);
      chk({tag, " aw_cyc"}, awc + wc, 0);
    end
  endtask

  initial begin
    bit hit;
    int pulses;
    //        wr rd addr          data          be     aw w ar rw resp    rdata         exp_addr      lat err
    vt[0] = '{1, 0, 32'h1000_0006, 32'hCAFE_BABE, 4'hC, 0, 0, 0, 0, OKAY,   32'h0,        32'h1000_0004, 3, 0};
    vt[1] = '{0, 1, 32'h2000_0010, 32'h0,         4'h0, 0, 0, 4, 0, OKAY,   32'h1234_5678, 32'h2000_0010, 7, 0};
    vt[2] = '{1, 0, 32'h3000_0000, 32'h1122_3344, 4'hF, 4, 1, 0, 0, OKAY,   32'h0,        32'h3000_0000, 7, 0};
    vt[3] = '{0, 1, 32'h4000_0003, 32'h0,         4'h0, 0, 0, 0, 2, SLVERR, 32'hDEAD_0001, 32'h4000_0000, 5, 1};
    vt[4] = '{1, 0, 32'h5000_0008, 32'h5555_AAAA, 4'h0, 0, 0, 0, 1, DECERR, 32'h0,        32'h5000_0008, 4, 1};
    vt[5] = '{1, 1, 32'h6000_000D, 32'hA5A5_A5A5, 4'h3, 0, 0, 0, 0, OKAY,   32'h0,        32'h6000_000C, 3, 0};
    vt[6] = '{0, 1, 32'h7000_0004, 32'h0,         4'h0, 0, 0, 1, 0, EXOKAY, 32'h0F0F_0F0F, 32'h7000_0004, 4, 1};
    vt[7] = '{1, 0, 32'h8000_0010, 32'h0BAD_F00D, 4'h1, 0, 3, 0, 0, OKAY,   32'h0,        32'h8000_0010, 6, 0};
    vt[8] = '{0, 1, 32'h9000_0022, 32'h0,         4'h0, 0, 0, 0, 0, OKAY,   32'h7654_3210, 32'h9000_0020, 3, 0};

    rst_n = 0;
    dmem_addr = 0; dmem_write_data = 0; dmem_byte_enable = 0;
    dmem_read = 0; dmem_write = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; resp_wait = 0;
    cfg_resp = 0; cfg_rdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl",
        {25'd0, awvalid, wvalid, arvalid, bready, rready, dmem_ready,
         dmem_error}, 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rdata", dmem_read_data, 0);
    chk("prot", {26'd0, awprot, arprot}, 0);
    rst_n = 1;

    for (int k = 0; k < 8; k++) run(k, vt[k]);

    // abort a write while it waits for B
    @(negedge clk);
    drive(vt[0]);
    resp_wait = 10;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (bready) hit = 1;
    end
    chk("mid_reach_wr_resp", 32'(hit), 1);
    rst_n = 0; dmem_write = 0;
    @(negedge clk);
    chk("mid_rst_ctrl",
        {25'd0, awvalid, wvalid, arvalid, bready, rready, dmem_ready,
         dmem_error}, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rdata", dmem_read_data, 0);
    rst_n = 1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      pulses += int'(dmem_ready) + int'(busy);
    end
    chk("mid_rst_quiet", pulses, 0);

    run(8, vt[8]);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
